// File: rtl/i2s_tx.sv
// i2s_tx: I2S transmitter, 64fs bit clock, one stereo pair latched per frame.
// Ports: clk (system clock), reset (async, active-high), mclk_ena (master-clock
// enable), rate (frame-start strobe), l_in/r_in (sample pair), sample_req
// (pair captured, one clk after rate), sclk (bit clock), lrck (word select,
// 0 = left), sdout (serial data).
// Optional macro I2S_SDIN_EN adds a loop receiver: sdin in, rx_l/rx_r/rx_valid out.
module i2s_tx #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mclk_ena,
    input  logic          rate,
    input  logic [DW-1:0] l_in,
    input  logic [DW-1:0] r_in,
    output logic          sample_req,
    output logic          sclk,
    output logic          lrck,
    output logic          sdout
`ifdef I2S_SDIN_EN
    ,
    input  logic          sdin,
    output logic [DW-1:0] rx_l,
    output logic [DW-1:0] rx_r,
    output logic          rx_valid
`endif
);
    logic [7:0]  fcnt;
    logic [63:0] sh;
    logic [31:0] l_slot, r_slot;
    // Left-justify each sample below a leading zero: bit 31 is the I2S delay slot.
    assign l_slot = 32'(l_in) << (31 - DW);
    assign r_slot = 32'(r_in) << (31 - DW);
    assign sclk  = fcnt[1];
    assign lrck  = fcnt[7];
    assign sdout = sh[63];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fcnt       <= '0;
            sh         <= '0;
            sample_req <= 1'b0;
        end else begin
            sample_req <= rate;
            if (rate)
                fcnt <= '0;
            else if (mclk_ena)
                fcnt <= fcnt + 8'd1;
            // Shift just before sclk falls so data is stable across the rising edge.
            if (rate)
                sh <= {l_slot, r_slot};
            else if (mclk_ena && fcnt[1:0] == 2'b11)
                sh <= {sh[62:0], 1'b0};
        end
    end
`ifdef I2S_SDIN_EN
    logic [63:0] rx_sh;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_sh    <= '0;
            rx_l     <= '0;
            rx_r     <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= rate;
            if (rate) begin
                rx_l <= rx_sh[62 -: DW];
                rx_r <= rx_sh[30 -: DW];
            end else if (mclk_ena && fcnt[1:0] == 2'b01) begin
                rx_sh <= {rx_sh[62:0], sdin};
            end
        end
    end
`endif
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: scoreboard bench for i2s_tx; stimulus pushes expected slots, monitor checks on sclk rises.
module tb_i2s_tx;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mclk_ena = 1'b0;
    logic        rate = 1'b0;
    logic [15:0] l_in = '0;
    logic [15:0] r_in = '0;
    logic        sample_req, sclk, lrck, sdout;
`ifdef I2S_SDIN_EN
    logic [15:0] rx_l, rx_r;
    logic        rx_valid;
`endif

    i2s_tx #(.DW(16)) dut (
        .clk(clk), .reset(reset), .mclk_ena(mclk_ena), .rate(rate),
        .l_in(l_in), .r_in(r_in), .sample_req(sample_req),
        .sclk(sclk), .lrck(lrck), .sdout(sdout)
`ifdef I2S_SDIN_EN
        , .sdin(sdout), .rx_l(rx_l), .rx_r(rx_r), .rx_valid(rx_valid)
`endif
    );

    always #10 clk = ~clk;

    typedef struct {
        logic sd;
        logic lr;
    } exp_t;
    exp_t exp_q[$];
    logic [31:0] rx_q[$];

    int pass_cnt = 0;
    int total = 0;
    bit mon_en = 1'b0;
    logic sclk_q = 1'b0;
    logic req_exp;
    int ticks = 0;
    bit frame_ok = 1'b0;
    logic [15:0] cur_l, cur_r;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] b);
        total++;
        if (a !== b) $display("FAIL %s: got %0h expected %0h", n, a, b);
        else pass_cnt++;
    endtask

    always @(posedge clk or posedge reset) req_exp <= reset ? 1'b0 : rate;

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            chk("sample_req", sample_req, req_exp);
`ifdef I2S_SDIN_EN
            chk("rx_valid", rx_valid, sample_req);
            if (rx_valid && rx_q.size() > 0) chk("rx_pair", {rx_l, rx_r}, rx_q.pop_front());
`endif
            if (sclk && !sclk_q) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("sdout_slot", sdout, e.sd);
                    chk("lrck_slot", lrck, e.lr);
                end else begin
                    chk("sdout_idle", sdout, 1'b0);
                end
            end
            sclk_q = sclk;
        end
    end

    task automatic push_frame(input logic [15:0] l, input logic [15:0] r);
        exp_t e;
        exp_q.delete();
        for (int s = 0; s < 64; s++) begin
            e.lr = (s >= 32);
            e.sd = (s >= 1 && s <= 16) ? l[16-s] : (s >= 33 && s <= 48) ? r[48-s] : 1'b0;
            exp_q.push_back(e);
        end
    endtask

    // One master-clock period: three idle clks, then mclk_ena (optionally with rate).
    task automatic mtick(input bit r);
        mclk_ena = 1'b0;
        rate = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        mclk_ena = 1'b1;
        rate = r;
        if (r) begin
            if (frame_ok) begin
                chk("frame_complete", exp_q.size(), 0);
`ifdef I2S_SDIN_EN
                rx_q.push_back({cur_l, cur_r});
`endif
            end
            frame_ok = 1'b0;
            ticks = 0;
            cur_l = l_in;
            cur_r = r_in;
            push_frame(l_in, r_in);
        end else begin
            ticks++;
            if (ticks == 255) frame_ok = 1'b1;
        end
        @(posedge clk);
        #1;
        mclk_ena = 1'b0;
        rate = 1'b0;
    endtask

    task automatic check_zero(input string n);
        chk({n, "_sclk"}, sclk, 1'b0);
        chk({n, "_lrck"}, lrck, 1'b0);
        chk({n, "_sdout"}, sdout, 1'b0);
        chk({n, "_req"}, sample_req, 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #5 reset = 1'b0;
        @(posedge clk);
        #1 mon_en = 1'b1;
        repeat (10) mtick(1'b0);
        #4 reset = 1'b1;
        #1 check_zero("rst_async");
        @(posedge clk);
        #5 reset = 1'b0;
        @(posedge clk);
        #1;
        repeat (20) mtick(1'b0);
        l_in = 16'hA55A;
        r_in = 16'h0001;
        mtick(1'b1);
        repeat (50) mtick(1'b0);
        l_in = 16'h1234;
        repeat (205) mtick(1'b0);
        mtick(1'b1);
        repeat (99) mtick(1'b0);
        l_in = 16'h00F0;
        r_in = 16'h8000;
        mtick(1'b1);
        chk("early_sclk", sclk, 1'b0);
        chk("early_lrck", lrck, 1'b0);
        chk("early_sdout", sdout, 1'b0);
        repeat (255) mtick(1'b0);
        l_in = 16'hA55A;
        r_in = 16'h0001;
        mtick(1'b1);
        repeat (80) mtick(1'b0);
        #4 reset = 1'b1;
        exp_q.delete();
        frame_ok = 1'b0;
        #1 check_zero("rst_mid");
        @(posedge clk);
        #5 reset = 1'b0;
        @(posedge clk);
        #1;
        repeat (20) mtick(1'b0);
        mtick(1'b1);
        repeat (255) mtick(1'b0);
        mtick(1'b1);
        repeat (4) mtick(1'b0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
